// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the bit serializer: one-hot state encoding and the
// frame parity helper used to build parity_tag.
package bit_serializer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b001,
        ST_SHIFT = 3'b010,
        ST_GAP   = 3'b100
    } state_t;

    localparam int MAX_WIDTH = 64;

    // The zero count's parity follows from the one count's parity and the word width.
    function automatic logic [1:0] parityTag(input logic [MAX_WIDTH-1:0] word, input int width);
        logic onesOdd;
        onesOdd = ^word;
        return {onesOdd ^ width[0], onesOdd};
    endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: takes a WIDTH-bit word over valid/ready and
// emits it one bit per clock with frame markers and a parity tag.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             flush,
    output logic             dataout,
    output logic             dout_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic [1:0]       parity_tag,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic [GW-1:0]    r_gcnt;
    logic             r_dataout;
    logic             r_doutValid;
    logic             r_frameStart;
    logic [1:0]       r_parityTag;

    logic             w_lastBit;
    logic             w_dinReady;
    logic             w_accept;
    logic             w_firstBit;
    logic             w_nextBit;
    logic [WIDTH-1:0] w_loadShift;
    logic [WIDTH-1:0] w_stepShift;

    assign w_lastBit  = (r_state == ST_SHIFT) && (r_cnt == '0);
    assign w_dinReady = !flush && ((r_state == ST_IDLE) || (w_lastBit && (GAP_CYCLES == 0)));
    assign w_accept   = din_valid && w_dinReady;

    // The shift register always holds the bits still to be sent, aligned so the
    // next one sits at the outgoing end.
    assign w_firstBit  = MSB_FIRST ? din[WIDTH-1] : din[0];
    assign w_loadShift = MSB_FIRST ? (din << 1) : (din >> 1);
    assign w_nextBit   = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
    assign w_stepShift = MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);

    // Accept can only win in IDLE or on the last bit with no gap, so it is
    // checked ahead of the per-state behaviour; flush overrides everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_cnt        <= '0;
            r_gcnt       <= '0;
            r_dataout    <= 1'b0;
            r_doutValid  <= 1'b0;
            r_frameStart <= 1'b0;
            r_parityTag  <= 2'b00;
        end else if (flush) begin
            r_state      <= ST_IDLE;
            r_dataout    <= 1'b0;
            r_doutValid  <= 1'b0;
            r_frameStart <= 1'b0;
        end else if (w_accept) begin
            r_state      <= ST_SHIFT;
            r_shift      <= w_loadShift;
            r_cnt        <= CNT_LOAD;
            r_dataout    <= w_firstBit;
            r_doutValid  <= 1'b1;
            r_frameStart <= 1'b1;
            r_parityTag  <= parityTag(MAX_WIDTH'(din), WIDTH);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_IDLE;
                end
                ST_SHIFT: begin
                    if (r_cnt != '0) begin
                        r_shift      <= w_stepShift;
                        r_dataout    <= w_nextBit;
                        r_cnt        <= r_cnt - 1'b1;
                        r_frameStart <= 1'b0;
                    end else begin
                        r_state      <= (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
                        r_gcnt       <= GAP_LOAD;
                        r_dataout    <= 1'b0;
                        r_doutValid  <= 1'b0;
                        r_frameStart <= 1'b0;
                    end
                end
                ST_GAP: begin
                    if (r_gcnt == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_gcnt <= r_gcnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign din_ready   = w_dinReady;
    assign frame_end   = w_lastBit;
    assign dataout     = r_dataout;
    assign dout_valid  = r_doutValid;
    assign frame_start = r_frameStart;
    assign parity_tag  = r_parityTag;
    assign busy        = (r_state != ST_IDLE);

endmodule
